// File: rtl/bus_arbiter_pkg.sv
// Shared types and constants for the IF/MEM bus arbiter.
// State encodings are 3 bits wide so they match the core's state bus width.
package bus_arbiter_pkg;

  localparam int RegBus = 32;
  localparam logic [RegBus-1:0] ZeroWord = 32'h0000_0000;
  localparam logic [3:0] SelAll  = 4'b1111;
  localparam logic [3:0] SelNone = 4'b0000;

  typedef enum logic [2:0] {
    ArbIdle    = 3'd0,
    ArbIfBusy  = 3'd1,
    ArbMemBusy = 3'd2,
    ArbIfDone  = 3'd3,
    ArbMemDone = 3'd4
  } arb_state_e;

endpackage

// File: rtl/bus_arbiter_if.sv
// External single-port memory bus: req/ack handshake plus write/read data.
// The arbiter drives it through the master modport, the memory through the slave modport.
interface bus_arbiter_if;
  import bus_arbiter_pkg::*;

  logic              req;
  logic              we;
  logic [3:0]        sel;
  logic [RegBus-1:0] addr;
  logic [RegBus-1:0] wdata;
  logic [RegBus-1:0] rdata;
  logic              ack;

  modport master (output req, we, sel, addr, wdata, input rdata, ack);
  modport slave  (input req, we, sel, addr, wdata, output rdata, ack);

endinterface

// File: rtl/bus_arbiter.sv
// Shares one external memory bus between instruction fetch and data access.
// Data access wins over fetch; each access takes request, busy and done cycles.
module bus_arbiter
  import bus_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              if_ce_i,
  input  logic [RegBus-1:0] if_addr_i,
  output logic [RegBus-1:0] if_data_o,
  output logic              stallreq_from_if_o,
  input  logic              mem_ce_i,
  input  logic              mem_we_i,
  input  logic [3:0]        mem_sel_i,
  input  logic [RegBus-1:0] mem_addr_i,
  input  logic [RegBus-1:0] mem_data_i,
  output logic [RegBus-1:0] mem_data_o,
  output logic              stallreq_from_mem_o,
  input  logic              flush_i,
  bus_arbiter_if.master     bus
);

  arb_state_e        state_r;
  logic              discard_r;
  logic              req_r;
  logic              we_r;
  logic [3:0]        sel_r;
  logic [RegBus-1:0] addr_r;
  logic [RegBus-1:0] wdata_r;
  logic [RegBus-1:0] rdata_r;
  logic              stall_if_s;
  logic              stall_mem_s;

  // Arbitration FSM; bus signals stay registered and stable until ack
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ArbIdle;
      discard_r <= 1'b0;
      req_r     <= 1'b0;
      we_r      <= 1'b0;
      sel_r     <= SelNone;
      addr_r    <= ZeroWord;
      wdata_r   <= ZeroWord;
      rdata_r   <= ZeroWord;
    end else begin
      case (state_r)
        ArbIdle: begin
          if (mem_ce_i) begin
            req_r   <= 1'b1;
            we_r    <= mem_we_i;
            sel_r   <= mem_sel_i;
            addr_r  <= mem_addr_i;
            wdata_r <= mem_data_i;
            state_r <= ArbMemBusy;
          end else if (if_ce_i) begin
            req_r   <= 1'b1;
            we_r    <= 1'b0;
            sel_r   <= SelAll;
            addr_r  <= if_addr_i;
            wdata_r <= ZeroWord;
            state_r <= ArbIfBusy;
          end else begin
            state_r <= ArbIdle;
          end
        end
        ArbIfBusy: begin
          if (bus.ack) begin
            req_r     <= 1'b0;
            rdata_r   <= bus.rdata;
            discard_r <= 1'b0;
            // A flush seen at any point of the fetch, including the ack cycle, drops its result
            if (discard_r || flush_i) begin
              state_r <= ArbIdle;
            end else begin
              state_r <= ArbIfDone;
            end
          end else if (flush_i) begin
            discard_r <= 1'b1;
          end else begin
            discard_r <= discard_r;
          end
        end
        ArbMemBusy: begin
          if (bus.ack) begin
            req_r   <= 1'b0;
            rdata_r <= bus.rdata;
            state_r <= ArbMemDone;
          end else begin
            state_r <= ArbMemBusy;
          end
        end
        ArbIfDone:  state_r <= ArbIdle;
        ArbMemDone: state_r <= ArbIdle;
        default:    state_r <= ArbIdle;
      endcase
    end
  end

  // Stall requests follow the live enables and clear only in the matching done cycle
  always_comb begin
    stall_if_s  = 1'b0;
    stall_mem_s = 1'b0;
    if (rst) begin
      stall_if_s  = 1'b0;
      stall_mem_s = 1'b0;
    end else begin
      stall_if_s  = if_ce_i  && (state_r != ArbIfDone);
      stall_mem_s = mem_ce_i && (state_r != ArbMemDone);
    end
  end

  assign stallreq_from_if_o  = stall_if_s;
  assign stallreq_from_mem_o = stall_mem_s;
  assign if_data_o  = (state_r == ArbIfDone)  ? rdata_r : ZeroWord;
  assign mem_data_o = (state_r == ArbMemDone) ? rdata_r : ZeroWord;

  assign bus.req   = req_r;
  assign bus.we    = we_r;
  assign bus.sel   = sel_r;
  assign bus.addr  = addr_r;
  assign bus.wdata = wdata_r;

endmodule
